// File: rtl/if_prefetch_buffer.sv
// Instruction fetch stage: owns the PC, drives the ROM address and buffers {pc, inst} pairs.
// Optional macro IF_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module if_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_inst,
    output logic [31:0]       if_pc,
    output logic              misalign_err
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0] pc_q, pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic misalign_q, misalign_d;
    logic push, pop;

    logic [31:0] mem_pc_q   [DEPTH];
    logic [31:0] mem_inst_q [DEPTH];

    assign rom_addr     = pc_q[ROM_AW-1:0];
    assign misalign_err = misalign_q;

    // Handshake, head read-out and next-state for PC, pointers and occupancy
    always_comb begin
        if_valid   = (count_q != '0) & ~redirect_valid;
        pop        = if_valid & if_ready;
        push       = fetch_en & ~redirect_valid & ((count_q < CW'(DEPTH)) | pop);
        if_inst    = if_valid ? mem_inst_q[rd_ptr_q] : 32'h0;
        if_pc      = if_valid ? mem_pc_q[rd_ptr_q] : 32'h0;
        pc_d       = pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        misalign_d = 1'b0;
        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            misalign_d = |redirect_pc[1:0];
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // FIFO storage; contents are qualified by count, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= pc_q;
            mem_inst_q[wr_ptr_q] <= rom_inst;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;

    // Count pushes and cycles where a wanted fetch was blocked by a full FIFO
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (push) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (fetch_en & ~redirect_valid & ~push) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Testbench for if_prefetch_buffer: directed steps plus random traffic
// against a queue-based reference model.
module tb_if_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          ROM_AW   = 12;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              fetch_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_inst;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_inst;
    logic [31:0]       if_pc;
    logic              misalign_err;
`ifdef IF_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_stall;
`endif

    logic [31:0] rom [1024];

    int n_tests = 0;
    int n_fail  = 0;

    ent_t        q[$];
    logic [31:0] mpc;
    logic        mmis;
    logic [31:0] mfetch;
    logic [31:0] mstall;

    always #5 clk = ~clk;

    assign rom_inst = rom[rom_addr[11:2]];

    if_prefetch_buffer #(
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC),
        .ROM_AW(ROM_AW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .fetch_en(fetch_en),
        .rom_addr(rom_addr),
        .rom_inst(rom_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_inst(if_inst),
        .if_pc(if_pc),
        .misalign_err(misalign_err)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input logic rv);
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        ev = (q.size() != 0) && !rv;
        ei = ev ? q[0].inst : 32'h0;
        ep = ev ? q[0].pc : 32'h0;
        chk("if_valid", {31'h0, if_valid}, {31'h0, ev});
        chk("if_inst", if_inst, ei);
        chk("if_pc", if_pc, ep);
        chk("rom_addr", {20'h0, rom_addr}, {20'h0, mpc[ROM_AW-1:0]});
        chk("misalign_err", {31'h0, misalign_err}, {31'h0, mmis});
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, mfetch);
        chk("perf_stall", perf_stall, mstall);
`endif
    endtask

    // One clock cycle: drive, check at negedge, advance model across posedge
    task automatic step(input logic fe, input logic rdy, input logic rv, input logic [31:0] rp);
        bit popped;
        bit pushed;
        int sz;
        fetch_en       = fe;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(negedge clk);
        chk_outputs(rv);
        sz     = q.size();
        popped = 0;
        pushed = 0;
        if (rv) begin
            q.delete();
            mpc  = {rp[31:2], 2'b00};
            mmis = (rp[1:0] != 2'b00);
        end else begin
            mmis   = 1'b0;
            popped = (sz != 0) && rdy;
            pushed = fe && ((sz < DEPTH) || popped);
            if (popped) void'(q.pop_front());
            if (pushed) begin
                q.push_back('{pc: mpc, inst: rom[mpc[11:2]]});
                mpc = mpc + 32'd4;
            end
        end
        if (pushed) mfetch = mfetch + 32'd1;
        if (fe && !rv && !pushed) mstall = mstall + 32'd1;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset assertion, checked immediately, released after an edge
    task automatic do_reset();
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        q.delete();
        mpc    = RESET_PC;
        mmis   = 1'b0;
        mfetch = 32'h0;
        mstall = 32'h0;
        #1;
        chk_outputs(1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        rom[0]         = 32'h1FC00113;
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mpc    = RESET_PC;
        mmis   = 1'b0;
        mfetch = 32'h0;
        mstall = 32'h0;
        @(posedge clk);
        #1;

        do_reset();
        chk("rst_rom_addr", {20'h0, rom_addr}, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("full_rom_addr", {20'h0, rom_addr}, 32'h10);
        chk("full_if_pc", if_pc, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h44);
        chk("redir_rom_addr", {20'h0, rom_addr}, 32'h44);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        step(1'b0, 1'b0, 1'b1, 32'h46);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h48);
        step(1'b1, 1'b0, 1'b0, 32'h0);

        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3, 0) != 0),
                 $urandom_range(1, 0) == 1,
                 ($urandom_range(9, 0) == 0),
                 $urandom);
        end

        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
